// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the E-stage multiply/divide unit.
//   - E_mdu_op encoding constants (NONE..MTLO)
//   - default busy latencies for multiply and divide
//   - helper that classifies an op as a multi-cycle start
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_start(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/e_mult_div_unit_mdu_core.sv
// mdu_core: combinational result generation for mult/multu/div/divu.
// Ports:
//   op      in  4   operation code (mdu_pkg encoding)
//   rs, rt  in  32  operands
//   res_hi  out 32  product[63:32] or remainder
//   res_lo  out 32  product[31:0]  or quotient
//   res_wr  out 1   0 when the result must not be written (divide by zero)
import mdu_pkg::*;

module mdu_core (
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        res_wr
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_rs;
    logic [31:0] mag_rt;
    logic [31:0] dvs_s;
    logic [31:0] dvs_u;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_u;
    logic [31:0] r_u;

    // Sign-extended operands: the low 64 bits of the 64x64 product are the
    // exact signed 32x32 product.
    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // Signed divide works on magnitudes. 0x80000000 negates to itself, which
    // read as unsigned is the correct magnitude 2^31, so 0x80000000 / -1
    // yields quotient 0x80000000 and remainder 0 without a special case.
    assign mag_rs = rs[31] ? (32'd0 - rs) : rs;
    assign mag_rt = rt[31] ? (32'd0 - rt) : rt;

    // Divide-by-zero result is discarded; substitute 1 to keep the divider
    // free of undefined values.
    assign dvs_s = (rt == 32'd0) ? 32'd1 : mag_rt;
    assign dvs_u = (rt == 32'd0) ? 32'd1 : rt;

    assign q_mag = mag_rs / dvs_s;
    assign r_mag = mag_rs % dvs_s;
    assign q_u   = rs / dvs_u;
    assign r_u   = rs % dvs_u;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b1;
        case (op)
            MDU_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MDU_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MDU_DIV: begin
                res_lo = (rs[31] ^ rt[31]) ? (32'd0 - q_mag) : q_mag;
                res_hi = rs[31] ? (32'd0 - r_mag) : r_mag;
                res_wr = (rt != 32'd0);
            end
            MDU_DIVU: begin
                res_lo = q_u;
                res_hi = r_u;
                res_wr = (rt != 32'd0);
            end
            default: res_wr = 1'b0;
        endcase
    end

endmodule

// File: rtl/e_mult_div_unit.sv
// e_mult_div_unit: E-stage multiply/divide unit owning the HI/LO pair.
// Accepts mult/multu/div/divu in IDLE, holds E_busy for a fixed latency,
// then commits the latched result to HI/LO. mthi/mtlo write in zero cycles.
// Ports:
//   clk        in  1   system clock
//   reset      in  1   synchronous active-high reset
//   E_mdu_op   in  4   operation code (mdu_pkg encoding)
//   E_rs       in  32  multiplicand/dividend or mthi/mtlo source
//   E_rt       in  32  multiplier/divisor
//   E_flush    in  1   cancel in-flight op (only when MDU_FLUSH_EN is defined)
//   E_busy     out 1   registered, high while an op is in flight
//   E_mdu_out  out 32  HI for MFHI, LO for MFLO, else 0
// Build option: `define MDU_FLUSH_EN adds the E_flush port.
//
// state | meaning
// IDLE  | cnt == 0, accepting starts and mthi/mtlo
// BUSY  | cnt != 0, counting down; result commits on cnt 1->0
import mdu_pkg::*;

module e_mult_div_unit #(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_mdu_op,
    input  logic [31:0] E_rs,
    input  logic [31:0] E_rt,
`ifdef MDU_FLUSH_EN
    input  logic        E_flush,
`endif
    output logic        E_busy,
    output logic [31:0] E_mdu_out
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e      state;
    logic [CW-1:0] cnt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_wr;
    logic [31:0] core_hi;
    logic [31:0] core_lo;
    logic        core_wr;
    logic        flush;

`ifdef MDU_FLUSH_EN
    assign flush = E_flush;
`else
    assign flush = 1'b0;
`endif

    mdu_core u_core (
        .op     (E_mdu_op),
        .rs     (E_rs),
        .rt     (E_rt),
        .res_hi (core_hi),
        .res_lo (core_lo),
        .res_wr (core_wr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            E_busy <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            res_wr <= 1'b0;
        end else if (flush) begin
            state  <= IDLE;
            cnt    <= '0;
            E_busy <= 1'b0;
            res_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_start(E_mdu_op)) begin
                        res_hi <= core_hi;
                        res_lo <= core_lo;
                        res_wr <= core_wr;
                        cnt    <= is_div(E_mdu_op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state  <= BUSY;
                        E_busy <= 1'b1;
                    end else if (E_mdu_op == MDU_MTHI) begin
                        hi <= E_rs;
                    end else if (E_mdu_op == MDU_MTLO) begin
                        lo <= E_rs;
                    end
                end
                BUSY: begin
                    // The hazard unit must hold D until E_busy falls.
                    assert (E_mdu_op == MDU_NONE);
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state  <= IDLE;
                        E_busy <= 1'b0;
                        if (res_wr) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    E_busy <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        E_mdu_out = 32'd0;
        if (E_mdu_op == MDU_MFHI)
            E_mdu_out = hi;
        else if (E_mdu_op == MDU_MFLO)
            E_mdu_out = lo;
    end

endmodule

// File: tb/tb_e_mult_div_unit.sv
import mdu_pkg::*;

module tb_e_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic [3:0]  E_mdu_op;
    logic [31:0] E_rs;
    logic [31:0] E_rt;
`ifdef MDU_FLUSH_EN
    logic        E_flush;
`endif
    logic        E_busy;
    logic [31:0] E_mdu_out;

    int checks = 0;
    int errors = 0;

    // Reference architectural state
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    e_mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .E_mdu_op  (E_mdu_op),
        .E_rs      (E_rs),
        .E_rt      (E_rt),
`ifdef MDU_FLUSH_EN
        .E_flush   (E_flush),
`endif
        .E_busy    (E_busy),
        .E_mdu_out (E_mdu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural effect of an op, from plain 64-bit arithmetic.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p, q, r;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            MDU_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            MDU_MULTU: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
            MDU_DIV:   if (b != 0) begin
                q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0];
            end
            MDU_DIVU:  if (b != 0) begin
                up = ua / ub; m_lo = up[31:0]; up = ua % ub; m_hi = up[31:0];
            end
            MDU_MTHI:  m_hi = a;
            MDU_MTLO:  m_lo = a;
            default: ;
        endcase
    endtask

    function automatic int lat_of(input logic [3:0] op);
        if (op == MDU_MULT || op == MDU_MULTU) return MC;
        if (op == MDU_DIV || op == MDU_DIVU) return DC;
        return 0;
    endfunction

    task automatic read_hilo(input string tag);
        @(negedge clk);
        E_mdu_op = MDU_MFHI;
        #1 chk({tag, ".hi"}, E_mdu_out, m_hi);
        E_mdu_op = MDU_MFLO;
        #1 chk({tag, ".lo"}, E_mdu_out, m_lo);
        E_mdu_op = MDU_NONE;
        #1 chk({tag, ".none"}, E_mdu_out, 32'd0);
    endtask

    // Issue one op, count busy cycles (bounded), update model, read back.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        int n_busy;
        int first_busy;
        @(negedge clk);
        E_mdu_op = op; E_rs = a; E_rt = b;
        @(posedge clk);
        #1 E_mdu_op = MDU_NONE;
        n_busy = 0;
        first_busy = 0;
        for (int i = 0; i < lat_of(op) + 3; i++) begin
            @(negedge clk);
            if (i == 0) first_busy = int'(E_busy);
            if (E_busy) n_busy++;
        end
        chk({tag, ".busy_cycles"}, 32'(n_busy), 32'(lat_of(op)));
        chk({tag, ".busy_first"}, 32'(first_busy), (lat_of(op) > 0) ? 32'd1 : 32'd0);
        model(op, a, b);
        read_hilo(tag);
    endtask

    initial begin
        logic [3:0] ops [6];
        logic [3:0] op;
        logic [31:0] a, b;
        ops[0] = MDU_MULT; ops[1] = MDU_MULTU; ops[2] = MDU_DIV;
        ops[3] = MDU_DIVU; ops[4] = MDU_MTHI;  ops[5] = MDU_MTLO;
        m_hi = 0; m_lo = 0;
        reset = 1'b1; E_mdu_op = MDU_NONE; E_rs = 0; E_rt = 0;
`ifdef MDU_FLUSH_EN
        E_flush = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset.busy", 32'(E_busy), 32'd0);
        read_hilo("reset");

        // Directed cases, with literal expectations on top of the model.
        run_op("mult", MDU_MULT, 32'hFFFFFFFE, 32'd3);
        chk("mult.lit", m_hi ^ m_lo, 32'hFFFFFFFF ^ 32'hFFFFFFFA);
        run_op("multu", MDU_MULTU, 32'hFFFFFFFE, 32'd3);
        chk("multu.lit_hi", m_hi, 32'h2);
        run_op("div", MDU_DIV, 32'hFFFFFFF9, 32'd2);
        chk("div.lit_lo", m_lo, 32'hFFFFFFFD);
        run_op("divu", MDU_DIVU, 32'd7, 32'd2);
        chk("divu.lit", {m_hi[15:0], m_lo[15:0]}, 32'h0001_0003);

        // Clear back to a known state, then mthi followed by mflo.
        reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
        m_hi = 0; m_lo = 0;
        run_op("mthi", MDU_MTHI, 32'h12345678, 32'd0);
        run_op("mtlo", MDU_MTLO, 32'h00000055, 32'd0);
        run_op("div0", MDU_DIV, 32'd5, 32'd0);
        chk("div0.lit_lo", m_lo, 32'h55);
        run_op("divovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
        chk("divovf.lit", m_lo | m_hi, 32'h80000000);

        // Back-to-back: a new op in the first non-busy cycle.
        @(negedge clk);
        E_mdu_op = MDU_MULT; E_rs = 32'd6; E_rt = 32'd7;
        @(posedge clk); #1 E_mdu_op = MDU_NONE;
        repeat (MC) @(posedge clk);
        #1 E_mdu_op = MDU_MULTU; E_rs = 32'd9; E_rt = 32'd9;
        @(negedge clk);
        chk("b2b.idle_before", 32'(E_busy), 32'd0);
        @(posedge clk); #1 E_mdu_op = MDU_NONE;
        @(negedge clk);
        chk("b2b.busy_after", 32'(E_busy), 32'd1);
        repeat (MC) @(negedge clk);
        model(MDU_MULT, 32'd6, 32'd7);
        model(MDU_MULTU, 32'd9, 32'd9);
        read_hilo("b2b");

        // Reset during cycle 3 of a mult.
        run_op("premthi", MDU_MTHI, 32'hCAFEF00D, 32'd0);
        @(negedge clk);
        E_mdu_op = MDU_MULT; E_rs = 32'd100; E_rt = 32'd200;
        @(posedge clk); #1 E_mdu_op = MDU_NONE;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rstmid.busy", 32'(E_busy), 32'd0);
        m_hi = 0; m_lo = 0;
        read_hilo("rstmid");
        repeat (MC + 2) @(negedge clk);
        read_hilo("rstmid_late");

`ifdef MDU_FLUSH_EN
        run_op("prefl_hi", MDU_MTHI, 32'h0000AAAA, 32'd0);
        run_op("prefl_lo", MDU_MTLO, 32'h0000BBBB, 32'd0);
        @(negedge clk);
        E_mdu_op = MDU_DIV; E_rs = 32'd100; E_rt = 32'd7;
        @(posedge clk); #1 E_mdu_op = MDU_NONE;
        @(posedge clk); #1 E_flush = 1'b1;
        @(posedge clk); #1 E_flush = 1'b0;
        @(negedge clk);
        chk("flush.busy", 32'(E_busy), 32'd0);
        repeat (DC) @(negedge clk);
        read_hilo("flush");
        run_op("postfl", MDU_MULT, 32'hFFFFFFFF, 32'h7FFFFFFF);
`endif

        // Randomized mix checked against the model.
        for (int k = 0; k < 24; k++) begin
            op = ops[$urandom_range(0, 5)];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 5) == 0) b = 32'(int'($urandom_range(0, 20)) - 10);
            run_op($sformatf("rnd%0d", k), op, a, b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
